// File: rtl/ram_pkg.sv
// Shared command encoding and default geometry for the ram block.
// Optional macro RAM_INIT_EN: zero power-up value for memory and address registers.
package ram_pkg;

  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_ADDR_SIZE = 8;
  localparam int DATA_W        = 8;
  localparam int DIN_W         = 10;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  function automatic cmd_e decode_cmd(input logic [DIN_W-1:0] din);
    return cmd_e'(din[DIN_W-1:DIN_W-2]);
  endfunction

endpackage

// File: rtl/ram_mem_array.sv
// Storage for ram: synchronous write port, combinational read feeding the output register in ram.
// Optional macro RAM_INIT_EN: every word powers up as zero.
module ram_mem_array
  import ram_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 i_wr_en,
  input  logic [ADDR_SIZE-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]    i_wr_data,
  input  logic [ADDR_SIZE-1:0] i_rd_addr,
  output logic [DATA_W-1:0]    o_rd_data
);

`ifdef RAM_INIT_EN
  logic [DATA_W-1:0] r_mem [MEM_DEPTH] = '{default: '0};
`else
  logic [DATA_W-1:0] r_mem [MEM_DEPTH];
`endif

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // The read register lives in ram so the async reset can clear dout without touching storage.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ram.sv
// Command-driven single-port RAM: din[9:8] selects set-write-address, write, set-read-address, read.
// Optional macro RAM_INIT_EN: wr/rd address registers power up as zero.
module ram
  import ram_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic [DIN_W-1:0]  din,
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid
);

  cmd_e                 w_cmd;
  logic [DATA_W-1:0]    w_payload;
  logic [ADDR_SIZE-1:0] w_addr;
  logic                 w_wr_en;
  logic                 w_rd_en;
  logic [DATA_W-1:0]    w_rd_data;

`ifdef RAM_INIT_EN
  logic [ADDR_SIZE-1:0] r_wr_addr = '0;
  logic [ADDR_SIZE-1:0] r_rd_addr = '0;
`else
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
`endif
  logic [DATA_W-1:0]    r_dout;
  logic                 r_tx_valid;

  assign w_cmd     = decode_cmd(din);
  assign w_payload = din[DATA_W-1:0];
  assign w_addr    = w_payload[ADDR_SIZE-1:0];
  assign w_wr_en   = rx_valid && (w_cmd == CMD_WR_DATA);
  assign w_rd_en   = rx_valid && (w_cmd == CMD_RD_DATA);

  // Address registers survive reset so a read after reset still finds the pre-reset location.
  always_ff @(posedge clk) begin
    if (rx_valid) begin
      case (w_cmd)
        CMD_WR_ADDR: r_wr_addr <= w_addr;
        CMD_RD_ADDR: r_rd_addr <= w_addr;
        default:     ;
      endcase
    end
  end

  ram_mem_array #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_mem (
    .clk      (clk),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(r_wr_addr),
    .i_wr_data(w_payload),
    .i_rd_addr(r_rd_addr),
    .o_rd_data(w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout     <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_tx_valid <= w_rd_en;
      if (w_rd_en) begin
        r_dout <= w_rd_data;
      end
    end
  end

  assign dout     = r_dout;
  assign tx_valid = r_tx_valid;

endmodule

// File: tb/tb_ram.sv
// Directed plus randomised bench for ram with a reference model and expected-value queue.
module tb_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [9:0] din;
  logic [7:0] dout;
  logic       tx_valid;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] dout;
    logic       tx;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] m_mem [256];
  logic [7:0] m_wr;
  logic [7:0] m_rd;
  logic [7:0] m_dout;
  logic       m_tx;

  always #5 clk = ~clk;

  ram #(
    .MEM_DEPTH(256),
    .ADDR_SIZE(8)
  ) dut (
    .din     (din),
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_valid(rx_valid),
    .dout    (dout),
    .tx_valid(tx_valid)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: advance one edge and queue the expected outputs.
  task automatic model_step(input logic v, input logic [9:0] d);
    exp_t e;
    m_tx = 1'b0;
    if (v) begin
      case (d[9:8])
        2'b00: m_wr = d[7:0];
        2'b01: m_mem[m_wr] = d[7:0];
        2'b10: m_rd = d[7:0];
        default: begin
          m_dout = m_mem[m_rd];
          m_tx   = 1'b1;
        end
      endcase
    end
    e.dout = m_dout;
    e.tx   = m_tx;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [9:0] d, input string tag);
    exp_t e;
    @(negedge clk);
    rx_valid = v;
    din      = d;
    model_step(v, d);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 8'd1, 8'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_dout"}, dout, e.dout);
      chk({tag, "_tx_valid"}, {7'd0, tx_valid}, {7'd0, e.tx});
    end
  endtask

  // Asynchronous reset pulse: outputs must clear before any clock edge and stay clear.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    m_dout = 8'h00;
    m_tx   = 1'b0;
    chk({tag, "_async_dout"}, dout, 8'h00);
    chk({tag, "_async_tx"}, {7'd0, tx_valid}, 8'h00);
    @(posedge clk);
    #1;
    chk({tag, "_held_dout"}, dout, 8'h00);
    chk({tag, "_held_tx"}, {7'd0, tx_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b1;
    rx_valid = 1'b1;
    din      = 10'h3FF;
    m_dout   = 8'h00;
    m_tx     = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("por_dout", dout, 8'h00);
    chk("por_tx", {7'd0, tx_valid}, 8'h00);
    @(posedge clk);
    #1;
    chk("por_held_dout", dout, 8'h00);
    chk("por_held_tx", {7'd0, tx_valid}, 8'h00);
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n    = 1'b1;

    // Basic write then read.
    drive(1'b1, 10'h03C, "wr_addr");
    drive(1'b1, 10'h1A5, "wr_data");
    drive(1'b1, 10'h23C, "rd_addr");
    drive(1'b1, 10'h3FF, "rd_data");
    chk("basic_read_value", dout, 8'hA5);
    chk("basic_read_tx", {7'd0, tx_valid}, 8'h01);

    // Idle cycles with a read pattern on din must do nothing.
    drive(1'b0, 10'h3FF, "idle0");
    drive(1'b0, 10'h3FF, "idle1");
    chk("idle_dout_hold", dout, 8'hA5);
    drive(1'b1, 10'h300, "idle_reread");

    // Back-to-back reads keep tx_valid high on consecutive cycles.
    drive(1'b1, 10'h300, "b2b_read");
    chk("b2b_tx", {7'd0, tx_valid}, 8'h01);

    // Overwrite the same location without a new address.
    drive(1'b1, 10'h010, "ow_wa");
    drive(1'b1, 10'h111, "ow_wd1");
    drive(1'b1, 10'h122, "ow_wd2");
    drive(1'b1, 10'h210, "ow_ra");
    drive(1'b1, 10'h300, "ow_rd");
    chk("overwrite_value", dout, 8'h22);

    // Highest address boundary.
    drive(1'b1, 10'h0FF, "top_wa");
    drive(1'b1, 10'h1C3, "top_wd");
    drive(1'b1, 10'h2FF, "top_ra");
    drive(1'b1, 10'h3AA, "top_rd");
    chk("top_addr_value", dout, 8'hC3);

    // Reset mid-operation keeps memory and rd_addr.
    drive(1'b1, 10'h010, "mid_wa");
    drive(1'b1, 10'h15A, "mid_wd");
    drive(1'b1, 10'h210, "mid_ra");
    drive(1'b1, 10'h300, "mid_rd");
    reset_pulse("mid_reset");
    drive(1'b1, 10'h300, "post_reset_rd");
    chk("post_reset_value", dout, 8'h5A);
    chk("post_reset_tx", {7'd0, tx_valid}, 8'h01);

    // Fill every location so random reads never hit unwritten storage.
    for (int a = 0; a < 256; a++) begin
      drive(1'b1, {2'b00, 8'(a)}, "fill_wa");
      drive(1'b1, {2'b01, 8'($urandom)}, "fill_wd");
    end

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        reset_pulse("rnd_reset");
      end else begin
        drive($urandom_range(0, 3) != 0, 10'($urandom), "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
